// File: rtl/tau_recip_arbiter_pkg.sv
// Shared constants and FSM encoding for the reciprocal arbiter slice.
// Holds tau/recip widths, quotient width and the arbiter state enum.
package emu_recip_pkg;

  localparam int TAU_W      = 41;
  localparam int RECIP_W    = 32;
  localparam int DIV_SHIFT  = 41;
  localparam int QUOT_W     = DIV_SHIFT + 1;
  localparam int DIV_CYCLES = 42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/tau_recip_arbiter_if.sv
// Lane request / shared response bundle for tau_recip_arbiter.
// master: lanes (drive req_valid/req_tau); slave: the arbiter.
interface tau_recip_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int TAU_W   = emu_recip_pkg::TAU_W,
  parameter int RECIP_W = emu_recip_pkg::RECIP_W
) ();

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*TAU_W-1:0] req_tau;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [RECIP_W-1:0]     rsp_recip;
  logic                   rsp_div0;
  logic                   rsp_ovf;
  logic                   busy;

  modport master (
    output req_valid, req_tau,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_recip, rsp_div0, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_tau,
    output req_ready, rsp_valid, rsp_id,
    output rsp_recip, rsp_div0, rsp_ovf, busy
  );

endinterface

// File: rtl/tau_recip_arbiter_div.sv
// recip_seq_divider: bit-serial restoring divide of 2^DIV_SHIFT by divisor.
// Ports: start (load divisor), divisor, done (last step cycle), quotient.
module recip_seq_divider
  import emu_recip_pkg::*;
#(
  parameter int TAU_W     = emu_recip_pkg::TAU_W,
  parameter int DIV_SHIFT = emu_recip_pkg::DIV_SHIFT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [TAU_W-1:0]     divisor,
  output logic                 done,
  output logic [DIV_SHIFT:0]   quotient
);

  localparam int QW = DIV_SHIFT + 1;
  localparam int CW = $clog2(QW);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [TAU_W-1:0] dvs;
  logic [TAU_W:0]   rem;
  logic [QW-1:0]    quo;
  logic             dbit;
  logic             fits;
  logic [TAU_W:0]   shl;
  logic [TAU_W:0]   diff;

  // dividend is a single one at bit DIV_SHIFT
  assign dbit = (cnt == CW'(DIV_SHIFT));
  assign shl  = {rem[TAU_W-1:0], dbit};
  assign diff = shl - {1'b0, dvs};
  assign fits = rem[TAU_W] | (shl >= {1'b0, dvs});
  assign done = run && (cnt == '0);

  // includes the bit resolved this cycle, so it is final while done
  assign quotient = quo | (QW'(fits && run) << cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
      cnt <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CW'(QW - 1);
      dvs <= divisor;
      rem <= '0;
      quo <= '0;
    end else if (run) begin
      rem <= fits ? diff : shl;
      quo <= quotient;
      cnt <= cnt - 1'b1;
      if (cnt == '0) run <= 1'b0;
    end
  end

endmodule

// File: rtl/tau_recip_arbiter.sv
// Round-robin share of one serial 2^41/tau unit among N_REQ lanes.
// Ports: clk, reset (async high), bus (slave). Macro: RECIP_SAT_EN.
module tau_recip_arbiter
  import emu_recip_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAU_W     = emu_recip_pkg::TAU_W,
  parameter int RECIP_W   = emu_recip_pkg::RECIP_W,
  parameter int DIV_SHIFT = emu_recip_pkg::DIV_SHIFT
) (
  input  logic             clk,
  input  logic             reset,
  tau_recip_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int QW   = DIV_SHIFT + 1;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    gidx;
  logic [N_REQ-1:0]   grant;
  logic               any_req;
  int                 idx;
  logic               accept;
  logic [TAU_W-1:0]   sel_tau;
  logic               tau_zero;
  logic               div_done;
  logic [QW-1:0]      quotient;
  logic [RECIP_W-1:0] div_recip;
  logic               div_ovf;
  logic [ID_W-1:0]    rsp_id_q;
  logic [RECIP_W-1:0] recip_q;
  logic               div0_q;

  // first valid lane at or after rr_ptr, wrapping
  always_comb begin
    grant   = '0;
    gidx    = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_req && bus.req_valid[idx]) begin
        any_req    = 1'b1;
        gidx       = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign accept   = (state == ST_IDLE) && any_req;
  assign sel_tau  = bus.req_tau[int'(gidx)*TAU_W +: TAU_W];
  assign tau_zero = (sel_tau == '0);

  assign bus.req_ready =
    (state == ST_IDLE && !reset) ? grant : '0;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_recip = recip_q;
  assign bus.rsp_div0  = div0_q;

  recip_seq_divider #(
    .TAU_W     (TAU_W),
    .DIV_SHIFT (DIV_SHIFT)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && !tau_zero),
    .divisor  (sel_tau),
    .done     (div_done),
    .quotient (quotient)
  );

`ifdef RECIP_SAT_EN
  logic hi_set;
  logic ovf_q;
  assign hi_set    = |quotient[QW-1:RECIP_W];
  assign div_recip = hi_set ? '1 : quotient[RECIP_W-1:0];
  assign div_ovf   = hi_set;
  assign bus.rsp_ovf = ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (accept && tau_zero) begin
      ovf_q <= 1'b0;
    end else if (state == ST_DIV && div_done) begin
      ovf_q <= div_ovf;
    end
  end
`else
  logic unused_q_hi;
  assign unused_q_hi = ^quotient[QW-1:RECIP_W];
  assign div_recip   = quotient[RECIP_W-1:0];
  assign div_ovf     = 1'b0;
  assign bus.rsp_ovf = div_ovf;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      id_q     <= '0;
      rsp_id_q <= '0;
      recip_q  <= '0;
      div0_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            id_q   <= gidx;
            rr_ptr <= (gidx == ID_W'(N_REQ - 1)) ?
                      '0 : gidx + 1'b1;
            if (tau_zero) begin
              state    <= ST_RESP;
              rsp_id_q <= gidx;
              recip_q  <= '1;
              div0_q   <= 1'b1;
            end else begin
              state <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state    <= ST_RESP;
            rsp_id_q <= id_q;
            recip_q  <= div_recip;
            div0_q   <= 1'b0;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tau_recip_arbiter.sv
// Self-checking bench for tau_recip_arbiter (4 lanes, 41-bit tau).
// Table vectors plus grant-order, tau==0 and reset-abort sequences.
module tb_tau_recip_arbiter;

  localparam int N  = 4;
  localparam int TW = 41;
  localparam int RW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tau_recip_arbiter_if #(
    .N_REQ(N), .TAU_W(TW), .RECIP_W(RW)
  ) bus ();

  tau_recip_arbiter #(
    .N_REQ(N), .TAU_W(TW), .RECIP_W(RW), .DIV_SHIFT(41)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  function automatic void model(input logic [TW-1:0] tau,
                                output logic [RW-1:0] r,
                                output logic d0,
                                output logic ov);
    logic [63:0] q;
    d0 = 1'b0;
    ov = 1'b0;
    if (tau == '0) begin
      r  = '1;
      d0 = 1'b1;
    end else begin
      q = (64'd1 << 41) / {23'd0, tau};
      r = q[31:0];
`ifdef RECIP_SAT_EN
      if (q[63:32] != 32'd0) begin
        r  = '1;
        ov = 1'b1;
      end
`endif
    end
  endfunction

  typedef struct {
    int          lane;
    logic [31:0] recip;
    logic        d0;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t sb[$];

  int          rsp_count = 0;
  int          last_acc_cyc = 0;
  logic [1:0]  last_rsp_id;
  logic [31:0] last_rsp_recip;
  logic        last_rsp_d0;
  logic        last_rsp_ov;

  // scoreboard: push on accept, pop on rsp_valid
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: id %0d recip 0x%0h",
                   bus.rsp_id, bus.rsp_recip);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_id", bus.rsp_id, e.lane);
          check("rsp_recip", bus.rsp_recip, e.recip);
          check("rsp_div0", bus.rsp_div0, e.d0);
          check("rsp_ovf", bus.rsp_ovf, e.ov);
          check("rsp_latency", cyc - e.acc, e.d0 ? 1 : 43);
        end
        last_rsp_id    = bus.rsp_id;
        last_rsp_recip = bus.rsp_recip;
        last_rsp_d0    = bus.rsp_div0;
        last_rsp_ov    = bus.rsp_ovf;
        rsp_count++;
      end
      if (bus.req_ready != '0) begin
        check("ready_onehot", $onehot(bus.req_ready), 1);
        check("ready_idle", bus.busy, 0);
        check("ready_valid",
              |(bus.req_ready & ~bus.req_valid), 0);
      end
      if (|(bus.req_valid & bus.req_ready)) begin
        exp_t e;
        for (int j = 0; j < N; j++)
          if (bus.req_valid[j] && bus.req_ready[j])
            e.lane = j;
        model(bus.req_tau[e.lane*TW +: TW],
              e.recip, e.d0, e.ov);
        e.acc = cyc;
        sb.push_back(e);
        last_acc_cyc = cyc;
      end
    end
  end

  task automatic wait_accept(input int bound,
                             output int lane);
    bit ok;
    ok   = 1'b0;
    lane = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (|(bus.req_valid & bus.req_ready)) begin
        for (int j = 0; j < N; j++)
          if (bus.req_valid[j] && bus.req_ready[j])
            lane = j;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: none in %0d cycles",
               bound);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int bound);
    int start;
    bit ok;
    start = rsp_count;
    ok    = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (rsp_count != start) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: none in %0d cycles", bound);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, bus.req_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_rsp_recip"}, bus.rsp_recip, 0);
    check({tag, "_rsp_div0"}, bus.rsp_div0, 0);
    check({tag, "_rsp_ovf"}, bus.rsp_ovf, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic set_lane(input int l, input logic [TW-1:0] t);
    bus.req_tau[l*TW +: TW] = t;
    bus.req_valid[l]        = 1'b1;
  endtask

  typedef struct {
    int          lane;
    logic [40:0] tau;
    logic [31:0] recip;
    logic        d0;
    logic        ov;
  } vec_t;

  vec_t        vt[9];
  logic [31:0] exp4[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int lane;
    int prev;
    int a0;
    int cnt0;

    vt[0] = '{0, 41'd1042, 32'd2110387001, 1'b0, 1'b0};
`ifdef RECIP_SAT_EN
    vt[1] = '{1, 41'd1, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vt[5] = '{0, 41'd512, 32'hFFFF_FFFF, 1'b0, 1'b1};
`else
    vt[1] = '{1, 41'd1, 32'd0, 1'b0, 1'b0};
    vt[5] = '{0, 41'd512, 32'd0, 1'b0, 1'b0};
`endif
    vt[2] = '{3, 41'd0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vt[3] = '{2, 41'd4096, 32'd536870912, 1'b0, 1'b0};
    vt[4] = '{1, 41'd65535, 32'd33554944, 1'b0, 1'b0};
    vt[6] = '{3, 41'd513, 32'd4286595040, 1'b0, 1'b0};
    vt[7] = '{2, 41'h1FF_FFFF_FFFF, 32'd1, 1'b0, 1'b0};
    vt[8] = '{0, 41'd2000, 32'd1099511627, 1'b0, 1'b0};

    exp4[0] = 32'd2110387001;
    exp4[1] = 32'd1099511627;
    exp4[2] = 32'd536870912;
    exp4[3] = 32'd33554944;

    // all lanes requesting while reset is held
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_tau   = '0;
    set_lane(0, 41'd1042);
    set_lane(1, 41'd2000);
    set_lane(2, 41'd4096);
    set_lane(3, 41'd65535);
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // round-robin from lane 0, 44-cycle spacing
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_accept(100, lane);
      check("t4_grant", lane, k);
      if (k > 0) check("t4_spacing", last_acc_cyc - prev, 44);
      prev = last_acc_cyc;
      check("t4_busy", bus.busy, 1);
      if (lane >= 0) bus.req_valid[lane] = 1'b0;
      wait_rsp(60);
      check("t4_recip", last_rsp_recip, exp4[k]);
      check("t4_id", last_rsp_id, k);
    end

    // single-lane vector table
    for (int v = 0; v < 9; v++) begin
      set_lane(vt[v].lane, vt[v].tau);
      wait_accept(20, lane);
      check("vec_grant", lane, vt[v].lane);
      bus.req_valid = '0;
      wait_rsp(60);
      check("vec_id", last_rsp_id, vt[v].lane);
      check("vec_recip", last_rsp_recip, vt[v].recip);
      check("vec_div0", last_rsp_d0, vt[v].d0);
      check("vec_ovf", last_rsp_ov, vt[v].ov);
    end

    // tau==0 held on lane 3: accepts two cycles apart
    set_lane(3, 41'd0);
    wait_accept(20, lane);
    a0 = last_acc_cyc;
    check("z_busy", bus.busy, 1);
    wait_accept(20, lane);
    check("z_grant", lane, 3);
    check("z_spacing", last_acc_cyc - a0, 2);
    bus.req_valid = '0;
    wait_rsp(10);

    // lane 2 held, lane 0 joins during DIV: 2, 0, 2
    set_lane(2, 41'd2000);
    wait_accept(20, lane);
    check("rr_first", lane, 2);
    prev = last_acc_cyc;
    set_lane(0, 41'd1042);
    wait_accept(100, lane);
    check("rr_wrap", lane, 0);
    check("rr_spacing0", last_acc_cyc - prev, 44);
    prev = last_acc_cyc;
    bus.req_valid[0] = 1'b0;
    wait_accept(100, lane);
    check("rr_back", lane, 2);
    check("rr_spacing2", last_acc_cyc - prev, 44);
    bus.req_valid = '0;
    wait_rsp(60);

    // reset 20 cycles into DIV aborts with no response
    set_lane(1, 41'd2000);
    wait_accept(20, lane);
    check("abort_grant", lane, 1);
    repeat (19) @(posedge clk);
    check("abort_busy", bus.busy, 1);
    cnt0 = rsp_count;
    #2 reset = 1'b1;
    #1;
    check_zero_outputs("abort");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_accept(20, lane);
    check("reacc_grant", lane, 1);
    check("abort_no_rsp", rsp_count, cnt0);
    bus.req_valid = '0;
    wait_rsp(60);
    check("reacc_recip", last_rsp_recip, 32'd1099511627);

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
